hsynth_capture_apb_dma: RTL and testbench
=========================================

// Module: hsynth_capture_apb_dma
// PURPOSE
//  Parametrised APB capture bridge with DMA handshake. Takes N_CH-channel synth sample frames, serialises each
//  channel into 32-bit words in an internal sync FIFO, and drains them over APB reads or SOCFPGA DMA.
//  Adds a watermark burst request, whole-frame drop on overflow, sticky error flags and an interrupt.
// PARAMETERS
//  N_CH      2   channels per frame, 1..8
//  SAMPLE_W  24  bits per channel sample, 1..32; sign-extended to 32 bits in the FIFO
//  DEPTH     64  FIFO depth in 32-bit words, power of 2, >= N_CH
//  LVL_W     $clog2(DEPTH)+1  level counter width (derived)
// PORTS
//  clk                 in   1             single interface/system clock, all logic on posedge
//  reset               in   1             synchronous, active-high
//  paddr               in   5             APB byte address
//  psel                in   1             APB select
//  penable             in   1             APB enable
//  pwrite              in   1             APB write strobe
//  pwdata              in   32            APB write data
//  prdata              out  32            APB read data, registered
//  pready              out  1             = penable, no wait states
//  capture_valid       in   1             1-cycle strobe: capture_data holds one frame
//  capture_data        in   N_CH*SAMPLE_W ch0 in LSBs
//  capture_busy        out  1             serialiser active; frames offered now are dropped
//  capture_dma_req     out  1             burst request
//  capture_dma_single  out  1             single request
//  capture_dma_ack     in   1             DMA acknowledge
//  irq                 out  1             level interrupt
// BEHAVIOUR
//  Reset: FIFO empty; all regs 0; prdata=0; dma_req/single, irq, capture_busy = 0; serialiser IDLE.
//  Register map: 0x00 DATA (RO, pops), 0x04 STATUS (RO), 0x08 CMD (RW), 0x0C WMARK (RW, [LVL_W-1:0]).
//  APB setup phase (psel & ~penable & ~pwrite): prdata <= selected reg; DATA gives FIFO head, 0 when empty.
//  Access phase (psel & penable):
//   - writes update CMD/WMARK;
//   - a DATA read pops 1 word; a DATA read while empty sets UNDERFLOW and does not pop.
//   - Writes to 0x00/0x04 and unmapped addresses: ignored; unmapped reads return 0.
//  CMD: [0] FIFO clear (pulse, self-clears next cycle), [1] capture enable, [2] DMA enable, [3] IRQ enable,
//   [4] flag clear (pulse, clears OVERFLOW/UNDERFLOW).
//  STATUS: [0] empty, [1] full, [2] OVERFLOW, [3] UNDERFLOW, [4] dma_single, [5] dma_req, [6] capture_busy,
//   [31:16] level (zero-extended). Registered: 1-cycle lag.
//  Serialiser FSM IDLE->SHIFT->IDLE:
//   - In IDLE, capture_valid with enable=1: if (DEPTH-level) >= N_CH, latch frame, go SHIFT, busy=1.
//     Otherwise drop the whole frame and set OVERFLOW.
//   - SHIFT pushes ch k in cycle k+1 after the strobe, k=0..N_CH-1; returns to IDLE after the last push.
//   - capture_valid while in SHIFT: frame dropped, OVERFLOW set. enable=0: frames ignored, no flag.
//  FIFO: push and pop in the same cycle are allowed; level unchanged. Pointers wrap modulo DEPTH.
//   - Clear has priority over push/pop: empties the FIFO and aborts SHIFT to IDLE. Flags are untouched.
//  DMA (registered, dma_en=CMD[2]):
//   - single = dma_en & ~empty; req = dma_en & WMARK!=0 & level>=WMARK.
//   - capture_dma_ack forces both low for the following cycle; they re-evaluate after that.
//  irq = CMD[3] & ((WMARK!=0 & level>=WMARK) | OVERFLOW | UNDERFLOW), registered.
//  Mid-operation reset returns all state to reset values in one cycle; any partial frame is lost.
// STRUCTURE
//  Package hsynth_apb_pkg: register offsets (REG_DATA/STATUS/CMD/WMARK), CMD and STATUS bit indices,
//   serialiser state enum.
//  Sub-module hsynth_sync_fifo #(WIDTH=32, DEPTH): push, pop, clear, dout (show-ahead), empty, full, level.
//   Serialiser, APB decode and DMA/irq logic stay in the top.
// TESTING
//  1. N_CH=2, CMD=0x2, frame {ch1=24'h800000, ch0=24'h000123}:
//     -> FIFO holds 0x00000123 then 0xFF800000; level=2 at cycle 3 after the strobe.
//  2. DEPTH=64, fill to level 63, offer frame: dropped, level stays 63, OVERFLOW=1; CMD=0x12 -> OVERFLOW=0.
//  3. WMARK=8, CMD=0x6, push 4 frames: dma_single=1 at level 1, dma_req=1 at level 8.
//     Ack pulse -> both low 1 cycle, then high again.
//  4. Empty FIFO, APB DATA read: prdata=0, UNDERFLOW=1; with CMD[3]=1 irq=1 next cycle.
//  5. capture_valid on 2 consecutive cycles: 2nd frame dropped with OVERFLOW.
//     CMD clear during SHIFT -> level 0, FSM IDLE, busy=0.
//  6. Simultaneous DATA pop and serialiser push at level 5: level stays 5, pop data = old head.
//     Reset asserted mid-SHIFT -> all outputs 0.

Source files
------------

// File: rtl/hsynth_capture_apb_dma_pkg.sv
// Shared definitions for the capture APB/DMA bridge: register map, CMD/STATUS bit
// positions and the serialiser state encoding.
package hsynth_apb_pkg;

  localparam logic [4:0] REG_DATA   = 5'h00;
  localparam logic [4:0] REG_STATUS = 5'h04;
  localparam logic [4:0] REG_CMD    = 5'h08;
  localparam logic [4:0] REG_WMARK  = 5'h0C;

  localparam int unsigned CMD_CLR      = 0;
  localparam int unsigned CMD_CAP_EN   = 1;
  localparam int unsigned CMD_DMA_EN   = 2;
  localparam int unsigned CMD_IRQ_EN   = 3;
  localparam int unsigned CMD_FLAG_CLR = 4;

  localparam int unsigned ST_EMPTY  = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_OVF    = 2;
  localparam int unsigned ST_UDF    = 3;
  localparam int unsigned ST_SINGLE = 4;
  localparam int unsigned ST_REQ    = 5;
  localparam int unsigned ST_BUSY   = 6;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/hsynth_capture_apb_dma_if.sv
// APB slave bus bundle for the capture bridge.
interface hsynth_capture_apb_dma_if;
  logic [4:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata, pready);
endinterface

// File: rtl/hsynth_sync_fifo.sv
// Single-clock show-ahead FIFO with level counter; clear has priority over push/pop.
module hsynth_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hsynth_capture_apb_dma.sv
// Capture bridge: serialises multi-channel frames into a 32-bit FIFO drained over
// APB or DMA, with watermark burst request, overflow/underflow flags and interrupt.
module hsynth_capture_apb_dma
  import hsynth_apb_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  hsynth_capture_apb_dma_if.slave  apb,
  input  logic                     capture_valid,
  input  logic [N_CH*SAMPLE_W-1:0] capture_data,
  output logic                     capture_busy,
  output logic                     capture_dma_req,
  output logic                     capture_dma_single,
  input  logic                     capture_dma_ack,
  output logic                     irq
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  ser_state_t                state;
  ser_state_t                state_nxt;
  logic [N_CH*SAMPLE_W-1:0]  frame_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      frame_ok;
  logic                      frame_accept;
  logic                      frame_drop;
  logic                      last_push;
  logic signed [SAMPLE_W-1:0] cur_sample;

  logic [4:0]       cmd_q;
  logic [LVL_W-1:0] wmark_q;
  logic             ovf_q;
  logic             udf_q;
  logic [31:0]      status_q;
  logic [31:0]      prdata_q;
  logic             wm_hit;

  logic             apb_setup;
  logic             apb_access;
  logic             wr_cmd;
  logic             wr_wmark;
  logic             rd_data;

  logic             fifo_push;
  logic             fifo_clr;
  logic [31:0]      fifo_din;
  logic [31:0]      fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic [LVL_W-1:0] fifo_level;

  logic             unused_pwdata;

  assign apb_setup  = apb.psel & ~apb.penable & ~apb.pwrite;
  assign apb_access = apb.psel & apb.penable;
  assign wr_cmd     = apb_access & apb.pwrite & (apb.paddr == REG_CMD);
  assign wr_wmark   = apb_access & apb.pwrite & (apb.paddr == REG_WMARK);
  assign rd_data    = apb_access & ~apb.pwrite & (apb.paddr == REG_DATA);
  assign apb.pready = apb.penable;
  assign apb.prdata = prdata_q;
  assign unused_pwdata = ^apb.pwdata;

  assign fifo_clr  = cmd_q[CMD_CLR];
  assign frame_ok  = (LVL_W'(DEPTH) - fifo_level) >= LVL_W'(N_CH);
  assign last_push = (idx_q == IDX_W'(N_CH - 1));
  assign wm_hit    = (wmark_q != '0) && (fifo_level >= wmark_q);

  // Frame is shifted down one sample per push so channel k is always in the LSBs.
  assign cur_sample = frame_q[SAMPLE_W-1:0];
  assign fifo_din   = 32'(cur_sample);

  hsynth_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (fifo_clr),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (rd_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= SER_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SER_IDLE:  if (frame_accept) state_nxt = SER_SHIFT;
      SER_SHIFT: if (fifo_clr || last_push) state_nxt = SER_IDLE;
      default:   state_nxt = SER_IDLE;
    endcase
  end

  always_comb begin
    capture_busy = 1'b0;
    fifo_push    = 1'b0;
    frame_accept = 1'b0;
    frame_drop   = 1'b0;
    case (state)
      SER_IDLE: begin
        if (capture_valid && cmd_q[CMD_CAP_EN]) begin
          frame_accept = frame_ok;
          frame_drop   = ~frame_ok;
        end
      end
      SER_SHIFT: begin
        capture_busy = 1'b1;
        fifo_push    = 1'b1;
        frame_drop   = capture_valid & cmd_q[CMD_CAP_EN];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      idx_q   <= '0;
    end else if (frame_accept) begin
      frame_q <= capture_data;
      idx_q   <= '0;
    end else if (state == SER_SHIFT) begin
      frame_q <= frame_q >> SAMPLE_W;
      idx_q   <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q   <= '0;
      wmark_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      cmd_q[CMD_CLR]      <= 1'b0;
      cmd_q[CMD_FLAG_CLR] <= 1'b0;
      if (wr_cmd)   cmd_q   <= apb.pwdata[4:0];
      if (wr_wmark) wmark_q <= apb.pwdata[LVL_W-1:0];
      ovf_q <= (ovf_q & ~cmd_q[CMD_FLAG_CLR]) | frame_drop;
      udf_q <= (udf_q & ~cmd_q[CMD_FLAG_CLR]) | (rd_data & fifo_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
    end else begin
      status_q <= {16'(fifo_level), 9'd0, capture_busy, capture_dma_req,
                   capture_dma_single, udf_q, ovf_q, fifo_full, fifo_empty};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prdata_q <= '0;
    end else if (apb_setup) begin
      case (apb.paddr)
        REG_DATA:   prdata_q <= fifo_empty ? '0 : fifo_dout;
        REG_STATUS: prdata_q <= status_q;
        REG_CMD:    prdata_q <= 32'(cmd_q);
        REG_WMARK:  prdata_q <= 32'(wmark_q);
        default:    prdata_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      capture_dma_single <= 1'b0;
      capture_dma_req    <= 1'b0;
      irq                <= 1'b0;
    end else begin
      if (capture_dma_ack) begin
        capture_dma_single <= 1'b0;
        capture_dma_req    <= 1'b0;
      end else begin
        capture_dma_single <= cmd_q[CMD_DMA_EN] & ~fifo_empty;
        capture_dma_req    <= cmd_q[CMD_DMA_EN] & wm_hit;
      end
      irq <= cmd_q[CMD_IRQ_EN] & (wm_hit | ovf_q | udf_q);
    end
  end

endmodule

// File: tb/tb_hsynth_capture_apb_dma.sv
// Directed bench for hsynth_capture_apb_dma (N_CH=2, SAMPLE_W=24, DEPTH=64).
module tb_hsynth_capture_apb_dma;

  localparam int unsigned N_CH     = 2;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned DEPTH    = 64;

  logic clk = 1'b0;
  logic reset;
  logic capture_valid;
  logic [N_CH*SAMPLE_W-1:0] capture_data;
  logic capture_busy;
  logic capture_dma_req;
  logic capture_dma_single;
  logic capture_dma_ack;
  logic irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  hsynth_capture_apb_dma_if apb ();

  hsynth_capture_apb_dma #(
    .N_CH     (N_CH),
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH)
  ) u (
    .clk                (clk),
    .reset              (reset),
    .apb                (apb),
    .capture_valid      (capture_valid),
    .capture_data       (capture_data),
    .capture_busy       (capture_busy),
    .capture_dma_req    (capture_dma_req),
    .capture_dma_single (capture_dma_single),
    .capture_dma_ack    (capture_dma_ack),
    .irq                (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [4:0] addr, input logic [31:0] data);
    apb.paddr = addr; apb.pwdata = data; apb.pwrite = 1'b1;
    apb.psel = 1'b1; apb.penable = 1'b0;
    tick();
    apb.penable = 1'b1;
    tick();
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] addr, output logic [31:0] data);
    apb.paddr = addr; apb.pwrite = 1'b0;
    apb.psel = 1'b1; apb.penable = 1'b0;
    tick();
    apb.penable = 1'b1;
    tick();
    data = apb.prdata;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] data);
    tick();
    tick();
    apb_read(5'h04, data);
  endtask

  task automatic frame(input logic [23:0] c1, input logic [23:0] c0);
    capture_valid = 1'b1;
    capture_data  = {c1, c0};
    tick();
    capture_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [23:0] c1, input logic [23:0] c0);
    frame(c1, c0);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    capture_valid = 1'b0; capture_data = '0; capture_dma_ack = 1'b0;
    apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_prdata", apb.prdata, 32'h0);
    chk("rst_busy", {31'd0, capture_busy}, 32'h0);
    chk("rst_single", {31'd0, capture_dma_single}, 32'h0);
    chk("rst_req", {31'd0, capture_dma_req}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    read_status(rd); chk("rst_status", rd, 32'h0000_0001);

    // 1: frame serialised with sign extension
    apb_write(5'h08, 32'h2);
    frame(24'h800000, 24'h000123);
    chk("t1_busy_shift", {31'd0, capture_busy}, 32'h1);
    tick(); tick();
    chk("t1_busy_done", {31'd0, capture_busy}, 32'h0);
    read_status(rd); chk("t1_status_lvl2", rd, 32'h0002_0000);
    apb_read(5'h00, rd); chk("t1_word0", rd, 32'h0000_0123);
    apb_read(5'h00, rd); chk("t1_word1", rd, 32'hFF80_0000);
    read_status(rd); chk("t1_status_empty", rd, 32'h0000_0001);

    // 2: fill to full, pop to 63, frame dropped with OVERFLOW
    for (int i = 0; i < 32; i++) push_frame(24'(32'h101 + 2 * i), 24'(32'h100 + 2 * i));
    read_status(rd); chk("t2_status_full", rd, 32'h0040_0002);
    apb_read(5'h00, rd); chk("t2_pop_head", rd, 32'h0000_0100);
    push_frame(24'h00AAAA, 24'h00BBBB);
    chk("t2_busy_drop", {31'd0, capture_busy}, 32'h0);
    read_status(rd); chk("t2_status_ovf", rd, 32'h003F_0004);
    apb_write(5'h08, 32'h12);
    read_status(rd); chk("t2_status_flagclr", rd, 32'h003F_0000);
    apb_write(5'h08, 32'h03);
    read_status(rd); chk("t2_status_clear", rd, 32'h0000_0001);

    // 3: DMA single/burst request and ack
    apb_write(5'h0C, 32'h8);
    apb_write(5'h08, 32'h6);
    push_frame(24'h000002, 24'h000001);
    chk("t3_single_lvl1", {31'd0, capture_dma_single}, 32'h1);
    chk("t3_req_low", {31'd0, capture_dma_req}, 32'h0);
    push_frame(24'h000004, 24'h000003);
    push_frame(24'h000006, 24'h000005);
    push_frame(24'h000008, 24'h000007);
    chk("t3_req_lag", {31'd0, capture_dma_req}, 32'h0);
    tick();
    chk("t3_req_lvl8", {31'd0, capture_dma_req}, 32'h1);
    chk("t3_irq_off", {31'd0, irq}, 32'h0);
    capture_dma_ack = 1'b1;
    tick();
    capture_dma_ack = 1'b0;
    chk("t3_ack_req", {31'd0, capture_dma_req}, 32'h0);
    chk("t3_ack_single", {31'd0, capture_dma_single}, 32'h0);
    tick();
    chk("t3_reeval_req", {31'd0, capture_dma_req}, 32'h1);
    chk("t3_reeval_single", {31'd0, capture_dma_single}, 32'h1);
    apb_read(5'h0C, rd); chk("t3_wmark_rd", rd, 32'h8);
    apb_read(5'h08, rd); chk("t3_cmd_rd", rd, 32'h6);

    // 4: underflow and irq
    apb_write(5'h08, 32'h3);
    apb_write(5'h0C, 32'h0);
    tick(); tick();
    apb_read(5'h00, rd); chk("t4_empty_read", rd, 32'h0);
    read_status(rd); chk("t4_status_udf", rd, 32'h0000_0009);
    apb_write(5'h08, 32'hA);
    tick();
    chk("t4_irq_udf", {31'd0, irq}, 32'h1);
    apb_write(5'h08, 32'h1A);
    tick(); tick();
    chk("t4_irq_cleared", {31'd0, irq}, 32'h0);
    apb_read(5'h08, rd); chk("t4_cmd_selfclr", rd, 32'h0000_000A);
    apb_read(5'h10, rd); chk("t4_unmapped", rd, 32'h0);

    // 5: back-to-back strobes, then clear during SHIFT
    capture_valid = 1'b1; capture_data = {24'h000002, 24'h000001};
    tick();
    capture_data = {24'h000004, 24'h000003};
    tick();
    capture_valid = 1'b0;
    tick();
    chk("t5_irq_ovf", {31'd0, irq}, 32'h1);
    read_status(rd); chk("t5_status_ovf", rd, 32'h0002_0004);
    apb_write(5'h08, 32'h13);
    read_status(rd); chk("t5_status_clr", rd, 32'h0000_0001);
    capture_valid = 1'b1; capture_data = {24'h000022, 24'h000011};
    apb.paddr = 5'h08; apb.pwdata = 32'h3; apb.pwrite = 1'b1; apb.psel = 1'b1; apb.penable = 1'b0;
    tick();
    capture_valid = 1'b0; apb.penable = 1'b1;
    tick();
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    chk("t5_busy_mid", {31'd0, capture_busy}, 32'h1);
    tick();
    chk("t5_busy_abort", {31'd0, capture_busy}, 32'h0);
    read_status(rd); chk("t5_status_abort", rd, 32'h0000_0001);

    // 6: simultaneous pop and push at level 5
    push_frame(24'hA00001, 24'hA00000);
    push_frame(24'hA00003, 24'hA00002);
    push_frame(24'hA00005, 24'hA00004);
    apb_read(5'h00, rd); chk("t6_pop_w0", rd, 32'hFFA0_0000);
    capture_valid = 1'b1; capture_data = {24'h000077, 24'h000066};
    apb.paddr = 5'h00; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
    tick();
    capture_valid = 1'b0; apb.penable = 1'b1;
    tick();
    apb.psel = 1'b0; apb.penable = 1'b0;
    chk("t6_pop_old_head", apb.prdata, 32'hFFA0_0001);
    chk("t6_level_same", 32'(u.fifo_level), 32'd5);
    tick();
    read_status(rd); chk("t6_status_lvl6", rd, 32'h0006_0000);
    apb_read(5'h00, rd); chk("t6_pop_w2", rd, 32'hFFA0_0002);

    // reset mid-SHIFT
    apb_write(5'h0C, 32'h1);
    apb_write(5'h08, 32'hE);
    tick(); tick();
    chk("t6_pre_single", {31'd0, capture_dma_single}, 32'h1);
    chk("t6_pre_req", {31'd0, capture_dma_req}, 32'h1);
    chk("t6_pre_irq", {31'd0, irq}, 32'h1);
    frame(24'h000099, 24'h000088);
    chk("t6_pre_busy", {31'd0, capture_busy}, 32'h1);
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", {31'd0, capture_busy}, 32'h0);
    chk("t6_rst_single", {31'd0, capture_dma_single}, 32'h0);
    chk("t6_rst_req", {31'd0, capture_dma_req}, 32'h0);
    chk("t6_rst_irq", {31'd0, irq}, 32'h0);
    chk("t6_rst_prdata", apb.prdata, 32'h0);
    reset = 1'b0;
    read_status(rd); chk("t6_rst_status", rd, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
